// File: rtl/bram_loader_pkg.sv
// Shared definitions for the BRAM0 loader and its row packer.
// The accessor uses the same state encoding so the controller can
// sequence both blocks with one status decode.
package bram_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DWIDTH_DEF = 32;                  // BRAM0 row width
  localparam int LANES      = 4;                   // elements per row
  localparam int LANE_BITS  = 2;                   // width of the lane index
  localparam int ELEM_WIDTH = DWIDTH_DEF / LANES;  // element width (DWIDTH/4)

endpackage

// File: rtl/bram_row_packer.sv
// Packs stream elements into BRAM rows, LSB byte first.
// Emits a flush strobe on the accept that completes a row or ends the run;
// 'row' then carries the full row with any unfilled upper lanes at zero.
module bram_row_packer
  import bram_loader_pkg::*;
#(
  parameter int EW     = ELEM_WIDTH,
  parameter int DWIDTH = EW * LANES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic              last,
  input  logic [EW-1:0]     data,
  output logic [DWIDTH-1:0] row,
  output logic              flush
);

  logic [LANE_BITS-1:0] lane_r;
  logic [DWIDTH-1:0]    pack_r;
  logic [DWIDTH-1:0]    row_s;
  logic                 flush_s;

  // Merge the incoming element into its lane and decide whether the row is finished.
  always_comb begin
    row_s = pack_r;
    case (lane_r)
      2'd0:    row_s[EW-1:0]        = data;
      2'd1:    row_s[2*EW-1:EW]     = data;
      2'd2:    row_s[3*EW-1:2*EW]   = data;
      2'd3:    row_s[4*EW-1:3*EW]   = data;
      default: row_s                = pack_r;
    endcase
    flush_s = accept && ((lane_r == 2'd3) || last);
  end

  // Lane counter and partial-row register; emptied on every flush so a short
  // final row is zero-filled.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      lane_r <= 2'd0;
      pack_r <= '0;
    end else if (accept) begin
      if (flush_s) begin
        lane_r <= 2'd0;
        pack_r <= '0;
      end else begin
        lane_r <= lane_r + 2'd1;
        pack_r <= row_s;
      end
    end
  end

  assign row   = row_s;
  assign flush = flush_s;

endmodule

// File: rtl/bram_loader.sv
// Stream-to-BRAM0 writer: accepts run_count_i 8-bit elements, packs four
// per row and writes rows to consecutive addresses from 0, then reports DONE.
module bram_loader
  import bram_loader_pkg::*;
#(
  parameter int CNT_BIT  = 31,
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int AWIDTH   = 8,
  parameter int MEM_SIZE = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_run_i,
  input  logic [CNT_BIT-1:0]  run_count_i,
  input  logic                s_valid_i,
  input  logic [DWIDTH/4-1:0] s_data_i,
  output logic                s_ready_o,
  output logic                idle_o,
  output logic                run_o,
  output logic                done_o,
  output logic [AWIDTH-1:0]   addr_b0_o,
  output logic                ce_b0_o,
  output logic                we_b0_o,
  output logic [DWIDTH-1:0]   d_b0_o
);

  localparam logic [CNT_BIT-1:0] CNT_ONE  = CNT_BIT'(1);
  localparam logic [AWIDTH-1:0]  ROW_ONE  = AWIDTH'(1);
  localparam logic [AWIDTH-1:0]  ROW_LAST = AWIDTH'(MEM_SIZE - 1);

  state_t             state_r;
  state_t             state_nx_s;
  logic [CNT_BIT-1:0] count_r;
  logic [CNT_BIT-1:0] elem_cnt_r;
  logic [AWIDTH-1:0]  row_idx_r;
  logic               ready_s;
  logic               accept_s;
  logic               last_s;
  logic               clear_s;
  logic [DWIDTH-1:0]  row_s;
  logic               flush_s;

  assign ready_s  = (state_r == S_RUN) && (elem_cnt_r < count_r);
  assign accept_s = s_valid_i && ready_s;
  assign last_s   = accept_s && ((elem_cnt_r + CNT_ONE) == count_r);
  assign clear_s  = (state_r == S_IDLE) && start_run_i;

  bram_row_packer #(
    .EW     (DWIDTH / LANES),
    .DWIDTH (DWIDTH)
  ) u_packer (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear_s),
    .accept (accept_s),
    .last   (last_s),
    .data   (s_data_i),
    .row    (row_s),
    .flush  (flush_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state: RUN ends once every element is in and the final row write is on the bus.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_run_i) begin
          if (run_count_i != '0) begin
            state_nx_s = S_RUN;
          end else begin
            state_nx_s = S_DONE;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_RUN: begin
        if ((elem_cnt_r == count_r) && ce_b0_o) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_RUN;
        end
      end
      S_DONE:  state_nx_s = S_IDLE;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Status decode and stream ready.
  always_comb begin
    idle_o    = (state_r == S_IDLE);
    run_o     = (state_r == S_RUN);
    done_o    = (state_r == S_DONE);
    s_ready_o = ready_s;
  end

  // Run bookkeeping: latched count, accepted-element counter and row index.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= '0;
      elem_cnt_r <= '0;
      row_idx_r  <= '0;
    end else if (clear_s) begin
      count_r    <= run_count_i;
      elem_cnt_r <= '0;
      row_idx_r  <= '0;
    end else begin
      if (accept_s) begin
        elem_cnt_r <= elem_cnt_r + CNT_ONE;
      end
      if (flush_s) begin
        row_idx_r <= (row_idx_r == ROW_LAST) ? '0 : row_idx_r + ROW_ONE;
      end
    end
  end

  // Registered BRAM0 port: one write cycle per completed row; address and data hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_b0_o   <= 1'b0;
      we_b0_o   <= 1'b0;
      addr_b0_o <= '0;
      d_b0_o    <= '0;
    end else begin
      ce_b0_o <= flush_s;
      we_b0_o <= flush_s;
      if (flush_s) begin
        addr_b0_o <= row_idx_r;
        d_b0_o    <= row_s;
      end
    end
  end

endmodule

// File: tb/tb_bram_loader.sv
// Self-checking bench for bram_loader: table of load runs checked against a
// row-level model, plus reset corner sequences.
module tb_bram_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_run_i;
  logic [30:0] run_count_i;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_ready_o;
  logic        idle_o;
  logic        run_o;
  logic        done_o;
  logic [7:0]  addr_b0_o;
  logic        ce_b0_o;
  logic        we_b0_o;
  logic [31:0] d_b0_o;

  bram_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start_run_i (start_run_i),
    .run_count_i (run_count_i),
    .s_valid_i   (s_valid_i),
    .s_data_i    (s_data_i),
    .s_ready_o   (s_ready_o),
    .idle_o      (idle_o),
    .run_o       (run_o),
    .done_o      (done_o),
    .addr_b0_o   (addr_b0_o),
    .ce_b0_o     (ce_b0_o),
    .we_b0_o     (we_b0_o),
    .d_b0_o      (d_b0_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Bus monitor: record every write, ce/we disagreement and done cycle.
  logic [7:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  int          done_n = 0;
  int          rw_bad = 0;
  always @(negedge clk) begin
    if (ce_b0_o === 1'b1) begin
      obs_addr.push_back(addr_b0_o);
      obs_data.push_back(d_b0_o);
    end
    if (ce_b0_o !== we_b0_o) rw_bad++;
    if (done_o === 1'b1) done_n++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          n;
    int          mode;      // 0: bytes k+1, 1: AA,BB,CC.., 2: random
    int          vprob;     // percent chance s_valid_i is offered
    bit          extra;     // pulse start_run_i mid-run
    int          exp_rows;
    bit          chk_c;
    logic [31:0] row0;
    logic [31:0] rowl;
    logic [7:0]  laddr;
  } vec_t;

  vec_t vecs[8];

  // One complete load: drive start, stream n elements, check timing and written rows.
  task automatic run_load(input vec_t v);
    logic [7:0]  el[$];
    logic [31:0] ed[$];
    logic [7:0]  ea[$];
    logic [31:0] w;
    int idx, last_acc, c_start, t, lim;
    bit sent_extra, vv;
    for (int k = 0; k < v.n; k++) begin
      case (v.mode)
        0:       el.push_back(8'(k + 1));
        1:       el.push_back(8'hAA + 8'(k * 17));
        default: el.push_back(8'($urandom));
      endcase
    end
    for (int r = 0; r * 4 < v.n; r++) begin
      w = 32'd0;
      for (int ln = 0; ln < 4; ln++)
        if (r * 4 + ln < v.n) w[ln*8 +: 8] = el[r*4 + ln];
      ed.push_back(w);
      ea.push_back(8'(r % 256));
    end
    obs_addr.delete();
    obs_data.delete();
    done_n = 0;
    rw_bad = 0;
    start_run_i = 1'b1;
    run_count_i = 31'(v.n);
    s_valid_i   = 1'b0;
    c_start     = cyc;
    step();
    start_run_i = 1'b0;
    last_acc   = c_start - 1;
    idx        = 0;
    t          = 0;
    sent_extra = 1'b0;
    while (idx < v.n && t < 20000) begin
      chk("ready_in_run", s_ready_o, 1);
      vv = ($urandom_range(99) < v.vprob);
      s_valid_i = vv;
      s_data_i  = vv ? el[idx] : 8'($urandom);
      if (v.extra && !sent_extra && idx == v.n / 2) begin
        start_run_i = 1'b1;
        run_count_i = 31'($urandom_range(50, 1));
        sent_extra  = 1'b1;
      end
      if (vv) begin
        idx++;
        last_acc = cyc;
      end
      step();
      start_run_i = 1'b0;
      t++;
    end
    if (idx < v.n) chk("accept_timeout", 64'(idx), 64'(v.n));
    lim = 0;
    while (cyc < last_acc + 2 && lim < 10) begin
      chk("ready_after_last", s_ready_o, 0);
      s_valid_i = 1'($urandom);
      s_data_i  = 8'($urandom);
      step();
      lim++;
    end
    chk("done_pulse", done_o, 1);
    chk("idle_during_done", idle_o, 0);
    s_valid_i = 1'b1;
    step();
    chk("idle_after_done", idle_o, 1);
    chk("done_low", done_o, 0);
    chk("ready_in_idle", s_ready_o, 0);
    chk("done_count", 64'(done_n), 1);
    chk("row_count", 64'(obs_data.size()), 64'(v.exp_rows));
    for (int r = 0; r < ed.size() && r < obs_data.size(); r++) begin
      chk("row_data", obs_data[r], ed[r]);
      chk("row_addr", obs_addr[r], ea[r]);
    end
    if (v.chk_c && obs_data.size() > 0) begin
      chk("row0_const", obs_data[0], v.row0);
      chk("rowlast_const", obs_data[obs_data.size()-1], v.rowl);
      chk("lastaddr_const", obs_addr[obs_addr.size()-1], v.laddr);
    end
    chk("ce_we_agree", 64'(rw_bad), 0);
    s_valid_i = 1'b0;
  endtask

  // Reset asserted part-way through a load: no further writes, immediate IDLE.
  task automatic reset_mid_run();
    obs_addr.delete();
    obs_data.delete();
    start_run_i = 1'b1;
    run_count_i = 31'd40;
    step();
    start_run_i = 1'b0;
    for (int k = 0; k < 10; k++) begin
      s_valid_i = 1'b1;
      s_data_i  = 8'($urandom);
      step();
    end
    reset = 1'b1;
    step();
    chk("rst_mid_idle", idle_o, 1);
    chk("rst_mid_run", run_o, 0);
    chk("rst_mid_ready", s_ready_o, 0);
    chk("rst_mid_ce", ce_b0_o, 0);
    for (int k = 0; k < 3; k++) step();
    reset     = 1'b0;
    s_valid_i = 1'b0;
    step();
    step();
    chk("rst_mid_writes", 64'(obs_data.size()), 64'(10 / 4));
    chk("rst_mid_still_idle", idle_o, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    vecs[0] = '{8,    0, 100, 1'b0, 2,   1'b1, 32'h04030201, 32'h08070605, 8'd1};
    vecs[1] = '{5,    1, 100, 1'b0, 2,   1'b1, 32'hDDCCBBAA, 32'h000000EE, 8'd1};
    vecs[2] = '{0,    0, 100, 1'b0, 0,   1'b0, 32'h0,        32'h0,        8'd0};
    vecs[3] = '{12,   0, 50,  1'b1, 3,   1'b1, 32'h04030201, 32'h0C0B0A09, 8'd2};
    vecs[4] = '{1028, 0, 100, 1'b0, 257, 1'b1, 32'h04030201, 32'h04030201, 8'd0};
    vecs[5] = '{7,    2, 60,  1'b1, 2,   1'b0, 32'h0,        32'h0,        8'd0};
    vecs[6] = '{1,    2, 80,  1'b0, 1,   1'b0, 32'h0,        32'h0,        8'd0};
    vecs[7] = '{33,   2, 40,  1'b1, 9,   1'b0, 32'h0,        32'h0,        8'd0};

    reset       = 1'b1;
    start_run_i = 1'b0;
    run_count_i = 31'd5;
    s_valid_i   = 1'b1;
    s_data_i    = 8'h55;
    step();
    step();
    step();
    chk("reset_idle", idle_o, 1);
    chk("reset_run", run_o, 0);
    chk("reset_done", done_o, 0);
    chk("reset_ready", s_ready_o, 0);
    chk("reset_ce", ce_b0_o, 0);
    chk("reset_we", we_b0_o, 0);
    chk("reset_addr", addr_b0_o, 0);
    chk("reset_data", d_b0_o, 0);
    chk("reset_no_write", 64'(obs_data.size()), 0);
    reset     = 1'b0;
    s_valid_i = 1'b0;
    step();
    chk("post_reset_idle", idle_o, 1);

    for (int i = 0; i < 8; i++) begin
      run_load(vecs[i]);
      step();
    end

    reset_mid_run();

    rv = '{21, 2, 70, 1'b1, 6, 1'b0, 32'h0, 32'h0, 8'd0};
    run_load(rv);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_loader.md
Name: bram_loader

Overview:
- Stream-to-BRAM writer that fills BRAM0 before the accumulate datapath reads it.
- Accepts 8-bit values over a valid/ready stream and packs four values per 32-bit row.
- Writes rows to consecutive BRAM0 addresses starting at 0.
- Exposes IDLE/RUN/DONE status, so the controller sequences loader, then accessor, with the same start_run_i / run_count_i handshake.

Parameters:
CNT_BIT, 31, width of run_count_i and of the internal element counter
DWIDTH, 32, BRAM0 row width (4 elements of DWIDTH/4 = 8 bits)
AWIDTH, 8, BRAM0 address width
MEM_SIZE, 256, BRAM0 depth in rows

Ports:
clk  in  1  clock
reset  in  1  synchronous reset, active-high
start_run_i  in  1  start pulse; sampled only in IDLE
run_count_i  in  CNT_BIT  number of 8-bit elements to load; latched at start
s_valid_i  in  1  stream element valid
s_data_i  in  DWIDTH/4  stream element
s_ready_o  out  1  loader can accept an element this cycle
idle_o  out  1  state == IDLE
run_o  out  1  state == RUN
done_o  out  1  state == DONE (one-cycle pulse)
addr_b0_o  out  AWIDTH  BRAM0 row address
ce_b0_o  out  1  BRAM0 chip enable
we_b0_o  out  1  BRAM0 write enable
d_b0_o  out  DWIDTH  BRAM0 write data

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset, evaluated at the clk rising edge.
- Reset values: state IDLE; idle_o=1; run_o=0; done_o=0; s_ready_o=0; ce_b0_o=0; we_b0_o=0; addr_b0_o=0; d_b0_o=0; all counters and the pack register cleared.
- Reset mid-operation: abort immediately; the partial pack register is discarded; no further BRAM write occurs.
- FSM transitions:
  - IDLE -> RUN on start_run_i=1 with run_count_i!=0; latch the count; element counter = 0; row address = 0.
  - IDLE -> DONE on start_run_i=1 with run_count_i==0; no BRAM access.
  - RUN -> DONE one cycle after the final row write (ce/we high) has been issued.
  - DONE -> IDLE unconditionally after 1 cycle.
- start_run_i in RUN or DONE is ignored.
- s_ready_o = 1 in RUN while accepted elements < latched count; otherwise 0. Comb from state and counter, not from s_valid_i.
- Accept: s_valid_i && s_ready_o. Throughput is 1 element/cycle with no bubbles, including across row boundaries.
- Packing: lane = count[1:0]. Element k goes to bits [8*(k%4)+7 : 8*(k%4)], so the first element is the LSB byte.
- Row write:
  - Issued when the accept completes a row (lane==3) or is the last element of the run.
  - Registered: in the cycle after that accept, ce_b0_o=we_b0_o=1 for exactly 1 cycle, with d_b0_o = the complete row and addr_b0_o = row index.
  - Row index then increments.
- Partial final row: unfilled upper lanes are written as 0.
- Outside write cycles: ce_b0_o=we_b0_o=0, and addr_b0_o/d_b0_o hold their last values. The loader never reads (we=0 with ce=1 never occurs).
- Rows written = ceil(N/4). Row index wraps modulo 2^AWIDTH. Counts above 4*MEM_SIZE overwrite from row 0 and are not flagged.
- Latency: done_o asserts 2 cycles after the last accept (write cycle, then DONE).
- Valid asserted while s_ready_o=0: no accept, data ignored, no state change.

Decomposition:
- Shared package: state encoding (S_IDLE=0, S_RUN=1, S_DONE=2) and the element width constant DWIDTH/4. The BRAM_accessor uses the same encoding.
- One natural sub-module, bram_row_packer: lane counter, pack register, row-complete and flush strobe. The top holds the FSM, the element counter and the BRAM interface registers.

Test Plan:
- Reset with s_valid_i=1 -> all outputs at reset values, idle_o=1, s_ready_o=0, no ce pulse.
- start, N=8, bytes 01..08 back-to-back:
  - row 0 = 0x04030201, row 1 = 0x08070605;
  - ce/we high on exactly 2 cycles;
  - done_o 2 cycles after last accept, then idle_o=1.
- N=5, bytes AA,BB,CC,DD,EE -> row 0 = 0xDDCCBBAA, row 1 = 0x000000EE; s_ready_o drops after the 5th accept.
- N=0 -> done_o pulses on the cycle after start; no ce_b0_o; back to IDLE.
- N=12 with s_valid_i toggling randomly, plus a start_run_i pulse mid-RUN -> same 3 rows as contiguous input; the extra start is ignored.
- N=1028 (257 rows) -> last row written to addr 0 (wrap). Reset asserted mid-run on a second load -> no further writes, idle_o=1 next cycle.
